// File: rtl/prt_dptx_scrm_if.sv
// PHY-style DisplayPort TX lane link between the lane mapper, the scrambler
// and the skew stage. Fields are indexed [lane][symbol]; only lane 0 is
// carried here.
//
// Handshake: there is none. The link streams one word every clock with no
// valid/ready. A word is whatever the source drives at each rising clock edge.
interface prt_dp_tx_phy_if #(
  parameter int P_SPL = 2
);
  logic [P_SPL-1:0] disp_ctl [0:0];
  logic [P_SPL-1:0] disp_val [0:0];
  logic [P_SPL-1:0] k        [0:0];
  logic [7:0]       dat      [0:0][0:P_SPL-1];

  modport src    (output disp_ctl, disp_val, k, dat);
  modport snk    (input  disp_ctl, disp_val, k, dat);
  modport master (output disp_ctl, disp_val, k, dat);
  modport slave  (input  disp_ctl, disp_val, k, dat);
endinterface

// File: rtl/prt_dptx_scrm.sv
// Per-lane DisplayPort TX scrambler. It scrambles data symbols with the DP
// LFSR (x^16+x^5+x^4+x^3+1) and replaces every 512th BS with SR. The LFSR
// restarts from FFFFh after each SR. The output is registered, so the latency
// is exactly one clock.
module prt_dptx_scrm #(
  parameter int P_SPL = 2
) (
  input  logic         CLK_IN,
  input  logic         RST_IN,
  input  logic         CTL_EN_IN,
  prt_dp_tx_phy_if.snk LNK_SNK_IF,
  prt_dp_tx_phy_if.src LNK_SRC_IF,
  output logic         STA_SR_OUT
);

  localparam logic [7:0]  C_BS   = 8'hBC;
  localparam logic [7:0]  C_SR   = 8'h1C;
  localparam logic [15:0] C_SEED = 16'hFFFF;
  localparam logic [8:0]  C_LAST = 9'd511;

  logic [15:0]      lfsr_r;
  logic [15:0]      lfsr_nxt;
  logic [8:0]       bs_cnt_r;
  logic [8:0]       bs_cnt_nxt;
  logic [P_SPL-1:0] k_nxt;
  logic [7:0]       dat_nxt [0:P_SPL-1];
  logic             sr_nxt;

  // Walk the word symbol by symbol in time order. The LFSR and the BS count
  // are chained through every symbol, so a mid-word SR reseeds the symbols
  // that follow it in the same word.
  always_comb begin : scramble_word
    logic [15:0] l;
    logic [8:0]  c;
    logic        fb;
    l      = lfsr_r;
    c      = bs_cnt_r;
    fb     = 1'b0;
    sr_nxt = 1'b0;
    for (int s = 0; s < P_SPL; s++) begin
      k_nxt[s]   = LNK_SNK_IF.k[0][s];
      dat_nxt[s] = LNK_SNK_IF.dat[0][s];
      if (CTL_EN_IN) begin
        if (k_nxt[s] && (dat_nxt[s] == C_SR)) begin
          // An upstream SR passes through, but it still reseeds the LFSR.
          l = C_SEED;
        end else if (k_nxt[s] && (dat_nxt[s] == C_BS) && (c == C_LAST)) begin
          dat_nxt[s] = C_SR;
          c          = '0;
          l          = C_SEED;
          sr_nxt     = 1'b1;
        end else begin
          if (k_nxt[s] && (dat_nxt[s] == C_BS)) begin
            c = c + 9'd1;
          end
          // Eight LFSR steps per symbol, LSB first. Only D symbols are XORed.
          for (int i = 0; i < 8; i++) begin
            fb = l[15];
            if (!k_nxt[s]) begin
              dat_nxt[s][i] = dat_nxt[s][i] ^ fb;
            end
            l = {l[14:5], l[4] ^ fb, l[3] ^ fb, l[2] ^ fb, l[1:0], fb};
          end
        end
      end
    end
    // In bypass the state is parked, so enabling starts from a clean seed.
    lfsr_nxt   = CTL_EN_IN ? l : C_SEED;
    bs_cnt_nxt = CTL_EN_IN ? c : '0;
  end

  // Register the scrambler state.
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      lfsr_r   <= C_SEED;
      bs_cnt_r <= '0;
    end else begin
      lfsr_r   <= lfsr_nxt;
      bs_cnt_r <= bs_cnt_nxt;
    end
  end

  // Register the output word. disp_ctl and disp_val are delayed unmodified.
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      LNK_SRC_IF.disp_ctl[0] <= '0;
      LNK_SRC_IF.disp_val[0] <= '0;
      LNK_SRC_IF.k[0]        <= '0;
      for (int s = 0; s < P_SPL; s++) begin
        LNK_SRC_IF.dat[0][s] <= '0;
      end
      STA_SR_OUT <= 1'b0;
    end else begin
      LNK_SRC_IF.disp_ctl[0] <= LNK_SNK_IF.disp_ctl[0];
      LNK_SRC_IF.disp_val[0] <= LNK_SNK_IF.disp_val[0];
      LNK_SRC_IF.k[0]        <= k_nxt;
      for (int s = 0; s < P_SPL; s++) begin
        LNK_SRC_IF.dat[0][s] <= dat_nxt[s];
      end
      STA_SR_OUT <= sr_nxt;
    end
  end

endmodule

// File: tb/tb_prt_dptx_scrm.sv
// Directed bench for prt_dptx_scrm. Two instances are used: a 2-symbol lane
// (a) and a 4-symbol lane (b). Expected scrambler bytes are the DP LFSR
// sequence from seed FFFFh: FF 17 C0 14 B2 E7 02 82 72 6E.
module tb_prt_dptx_scrm;

  logic clk;
  logic rst_n;
  logic en;
  logic sr_a;
  logic sr_b;
  int   n_checks;
  int   n_errors;

  prt_dp_tx_phy_if #(.P_SPL(2)) lnk_a_snk ();
  prt_dp_tx_phy_if #(.P_SPL(2)) lnk_a_src ();
  prt_dp_tx_phy_if #(.P_SPL(4)) lnk_b_snk ();
  prt_dp_tx_phy_if #(.P_SPL(4)) lnk_b_src ();

  prt_dptx_scrm #(.P_SPL(2)) u_dut_a (
    .CLK_IN     (clk),
    .RST_IN     (rst_n),
    .CTL_EN_IN  (en),
    .LNK_SNK_IF (lnk_a_snk),
    .LNK_SRC_IF (lnk_a_src),
    .STA_SR_OUT (sr_a)
  );

  prt_dptx_scrm #(.P_SPL(4)) u_dut_b (
    .CLK_IN     (clk),
    .RST_IN     (rst_n),
    .CTL_EN_IN  (en),
    .LNK_SNK_IF (lnk_b_snk),
    .LNK_SRC_IF (lnk_b_src),
    .STA_SR_OUT (sr_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_a(input logic [1:0] k, input logic [7:0] d0, input logic [7:0] d1);
    lnk_a_snk.k[0]      = k;
    lnk_a_snk.dat[0][0] = d0;
    lnk_a_snk.dat[0][1] = d1;
  endtask

  task automatic set_b(input logic [3:0] k, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3);
    lnk_b_snk.k[0]      = k;
    lnk_b_snk.dat[0][0] = d0;
    lnk_b_snk.dat[0][1] = d1;
    lnk_b_snk.dat[0][2] = d2;
    lnk_b_snk.dat[0][3] = d3;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // bypass vectors: {k, d0, d1, disp_ctl, disp_val}
  logic [1:0] byp_k  [0:5] = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b11, 2'b00};
  logic [7:0] byp_d0 [0:5] = '{8'h00, 8'hBC, 8'hBC, 8'h5A, 8'h1C, 8'hFF};
  logic [7:0] byp_d1 [0:5] = '{8'h00, 8'h1C, 8'h3C, 8'hBC, 8'hBC, 8'hA5};
  logic [1:0] byp_dc [0:5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
  logic [1:0] byp_dv [0:5] = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b11, 2'b01};

  logic [7:0] seq [0:9] = '{8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7, 8'h02, 8'h82, 8'h72, 8'h6E};

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    set_a(2'b00, 8'h00, 8'h00);
    set_b(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    lnk_a_snk.disp_ctl[0] = '0;
    lnk_a_snk.disp_val[0] = '0;
    lnk_b_snk.disp_ctl[0] = '0;
    lnk_b_snk.disp_val[0] = '0;

    // reset state
    #2;
    check("rst_a_dat0", {24'h0, lnk_a_src.dat[0][0]}, 32'h0);
    check("rst_a_dat1", {24'h0, lnk_a_src.dat[0][1]}, 32'h0);
    check("rst_a_k", {30'h0, lnk_a_src.k[0]}, 32'h0);
    check("rst_a_sr", {31'h0, sr_a}, 32'h0);
    check("rst_b_k", {28'h0, lnk_b_src.k[0]}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // scrambled zeros from seed
    en = 1'b1;
    for (int w = 0; w < 5; w++) begin
      step();
      check("seq_a_d0", {24'h0, lnk_a_src.dat[0][0]}, {24'h0, seq[2*w]});
      check("seq_a_d1", {24'h0, lnk_a_src.dat[0][1]}, {24'h0, seq[2*w+1]});
      check("seq_a_k", {30'h0, lnk_a_src.k[0]}, 32'h0);
    end

    // bypass: bit-exact one-clock delay, no SR
    en = 1'b0;
    for (int v = 0; v < 6; v++) begin
      set_a(byp_k[v], byp_d0[v], byp_d1[v]);
      lnk_a_snk.disp_ctl[0] = byp_dc[v];
      lnk_a_snk.disp_val[0] = byp_dv[v];
      step();
      check("byp_k", {30'h0, lnk_a_src.k[0]}, {30'h0, byp_k[v]});
      check("byp_d0", {24'h0, lnk_a_src.dat[0][0]}, {24'h0, byp_d0[v]});
      check("byp_d1", {24'h0, lnk_a_src.dat[0][1]}, {24'h0, byp_d1[v]});
      check("byp_dc", {30'h0, lnk_a_src.disp_ctl[0]}, {30'h0, byp_dc[v]});
      check("byp_dv", {30'h0, lnk_a_src.disp_val[0]}, {30'h0, byp_dv[v]});
      check("byp_sr", {31'h0, sr_a}, 32'h0);
    end
    lnk_a_snk.disp_ctl[0] = '0;
    lnk_a_snk.disp_val[0] = '0;

    // BS in symbol 0 of every word: SR on words 512 and 1024
    en = 1'b1;
    set_a(2'b01, 8'hBC, 8'h00);
    for (int w = 1; w <= 1024; w++) begin
      step();
      if (w == 512 || w == 1024) begin
        check("bs_sr_pulse", {31'h0, sr_a}, 32'h1);
        check("bs_sr_dat0", {24'h0, lnk_a_src.dat[0][0]}, 32'h1C);
        check("bs_sr_k0", {31'h0, lnk_a_src.k[0][0]}, 32'h1);
        check("bs_sr_dat1", {24'h0, lnk_a_src.dat[0][1]}, 32'hFF);
      end else begin
        check("bs_no_pulse", {31'h0, sr_a}, 32'h0);
        check("bs_dat0", {24'h0, lnk_a_src.dat[0][0]}, 32'hBC);
        check("bs_k0", {31'h0, lnk_a_src.k[0][0]}, 32'h1);
      end
    end

    // 4-symbol lane: preset count to 510, then SR lands in symbol 1
    set_b(4'b1111, 8'hBC, 8'hBC, 8'hBC, 8'hBC);
    repeat (127) step();
    set_b(4'b0011, 8'hBC, 8'hBC, 8'h00, 8'h00);
    step();
    check("b_pre_sr", {31'h0, sr_b}, 32'h0);
    set_b(4'b1111, 8'hBC, 8'hBC, 8'hBC, 8'hBC);
    step();
    check("b_sr_pulse", {31'h0, sr_b}, 32'h1);
    check("b_sr_k", {28'h0, lnk_b_src.k[0]}, 32'hF);
    check("b_sr_d0", {24'h0, lnk_b_src.dat[0][0]}, 32'hBC);
    check("b_sr_d1", {24'h0, lnk_b_src.dat[0][1]}, 32'h1C);
    check("b_sr_d2", {24'h0, lnk_b_src.dat[0][2]}, 32'hBC);
    check("b_sr_d3", {24'h0, lnk_b_src.dat[0][3]}, 32'hBC);
    // reseeded at symbol 2, then two BS advanced it by two bytes
    set_b(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    check("b_post_sr_pulse", {31'h0, sr_b}, 32'h0);
    check("b_post_d0", {24'h0, lnk_b_src.dat[0][0]}, 32'hC0);
    check("b_post_d1", {24'h0, lnk_b_src.dat[0][1]}, 32'h14);
    check("b_post_d2", {24'h0, lnk_b_src.dat[0][2]}, 32'hB2);
    check("b_post_d3", {24'h0, lnk_b_src.dat[0][3]}, 32'hE7);

    // asynchronous reset mid-stream
    set_a(2'b00, 8'h00, 8'h00);
    lnk_a_snk.disp_ctl[0] = 2'b11;
    lnk_a_snk.disp_val[0] = 2'b11;
    repeat (3) step();
    check("pre_rst_dc", {30'h0, lnk_a_src.disp_ctl[0]}, 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_a_d0", {24'h0, lnk_a_src.dat[0][0]}, 32'h0);
    check("arst_a_d1", {24'h0, lnk_a_src.dat[0][1]}, 32'h0);
    check("arst_a_dc", {30'h0, lnk_a_src.disp_ctl[0]}, 32'h0);
    check("arst_a_dv", {30'h0, lnk_a_src.disp_val[0]}, 32'h0);
    check("arst_b_d0", {24'h0, lnk_b_src.dat[0][0]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    lnk_a_snk.disp_ctl[0] = '0;
    lnk_a_snk.disp_val[0] = '0;
    step();
    check("rel_a_d0", {24'h0, lnk_a_src.dat[0][0]}, 32'hFF);
    check("rel_a_d1", {24'h0, lnk_a_src.dat[0][1]}, 32'h17);
    check("rel_b_d0", {24'h0, lnk_b_src.dat[0][0]}, 32'hFF);
    check("rel_b_d3", {24'h0, lnk_b_src.dat[0][3]}, 32'h14);

    // incoming SR: passed through, reseeds, BS count untouched
    set_a(2'b01, 8'hBC, 8'h00);
    repeat (300) step();
    set_a(2'b01, 8'h1C, 8'h00);
    step();
    check("in_sr_k0", {31'h0, lnk_a_src.k[0][0]}, 32'h1);
    check("in_sr_d0", {24'h0, lnk_a_src.dat[0][0]}, 32'h1C);
    check("in_sr_d1", {24'h0, lnk_a_src.dat[0][1]}, 32'hFF);
    check("in_sr_pulse", {31'h0, sr_a}, 32'h0);
    set_a(2'b01, 8'hBC, 8'h00);
    for (int w = 1; w <= 215; w++) begin
      step();
      if (w == 212) begin
        check("cnt_sr_pulse", {31'h0, sr_a}, 32'h1);
        check("cnt_sr_d0", {24'h0, lnk_a_src.dat[0][0]}, 32'h1C);
        check("cnt_sr_d1", {24'h0, lnk_a_src.dat[0][1]}, 32'hFF);
      end else begin
        check("cnt_no_pulse", {31'h0, sr_a}, 32'h0);
      end
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
